vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter.sv | 114 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: a non-preemptible per-line fetch into a ping-pong line buffer,
// with every remaining memory cycle handed to the pixel writer.
// state | meaning
// IDLE  | memory free for the writer; waiting for a line trigger
// FETCH | reading LINE_WORDS pixels of the next line, writer blocked
module vga_fb_arbiter #(
  parameter int H_TOTAL     = 1344,
  parameter int V_ACT_START = 38,
  parameter int V_ACT_LINES = 768,
  parameter int LINE_WORDS  = 1024,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 24,
  localparam int LW_W       = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LW_W:0]     lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              fetch_busy,
  output logic              overrun
);

  localparam logic [9:0] V_FIRST = 10'(V_ACT_START - 1);
  localparam logic [9:0] V_LAST  = 10'(V_ACT_START + V_ACT_LINES - 2);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [LW_W-1:0]   cnt;
  logic [LW_W-1:0]   rd_word;
  logic              bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] base;
  logic              trigger;
  logic [9:0]        line_idx;

  // A line is fetched during the line before it becomes visible.
  assign trigger  = (h_count == '0) && (v_count >= V_FIRST) && (v_count <= V_LAST);
  assign line_idx = v_count - V_FIRST;

  // Writer is never accepted while reset is held, nor when a fetch is about to start.
  assign wr_gnt     = reset && wr_req && (state == IDLE) && !trigger;
  assign fetch_busy = (state == FETCH);
  assign lb_wdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_word   <= '0;
      bank      <= 1'b0;
      rd_bank   <= 1'b0;
      base      <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      lb_we     <= 1'b0;
      lb_addr   <= '0;
      overrun   <= 1'b0;
    end else begin
      lb_we <= mem_re;
      if (mem_re)
        lb_addr <= {rd_bank, rd_word};

      case (state)
        IDLE: begin
          mem_re <= 1'b0;
          if (trigger) begin
            base   <= ADDR_W'(line_idx) << LW_W;
            bank   <= line_idx[0];
            cnt    <= '0;
            mem_we <= 1'b0;
            state  <= FETCH;
          end else if (wr_gnt) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_addr;
            mem_wdata <= wr_data;
          end else begin
            mem_we <= 1'b0;
          end
        end

        FETCH: begin
          mem_we   <= 1'b0;
          mem_re   <= 1'b1;
          mem_addr <= base + ADDR_W'(cnt);
          rd_word  <= cnt;
          rd_bank  <= bank;
          cnt      <= cnt + 1'b1;
          if (trigger)
            overrun <= 1'b1;
          if (cnt == LW_W'(LINE_WORDS - 1))
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: line fetches, writer grants, overrun and mid-burst reset.
module tb_vga_fb_arbiter;

  logic        clk;
  logic        reset;
  logic [10:0] h_count;
  logic [9:0]  v_count;
  logic        wr_req;
  logic [19:0] wr_addr;
  logic [23:0] wr_data;
  logic        wr_gnt;
  logic [19:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic        lb_we;
  logic [10:0] lb_addr;
  logic [23:0] lb_wdata;
  logic        fetch_busy;
  logic        overrun;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [19:0] wa_g  = 20'h00100;
  logic        exp_ovr = 1'b0;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .h_count(h_count), .v_count(v_count),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
    .fetch_busy(fetch_busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is a tagged copy of the address, one cycle after mem_re.
  always @(posedge clk)
    mem_rdata <= mem_re ? {4'hA, mem_addr} : 24'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full scan line; cycle j has h_count=j, edge E_j ends it (E_0 is the trigger edge).
  task automatic run_line(input int v, input bit fetch, input bit req);
    int          grants;
    logic [19:0] base;
    logic        bank;
    bit          exp_gnt, exp_re, exp_lbwe;
    grants  = 0;
    base    = fetch ? 20'((v - 37) * 1024) : 20'h0;
    bank    = fetch ? 1'((v - 37) % 2) : 1'b0;
    v_count = 10'(v);
    wr_req  = req;
    for (int j = 0; j < 1344; j++) begin
      h_count = 11'(j);
      wr_addr = wa_g;
      wr_data = {4'h5, wa_g};
      #1;
      exp_gnt = req && !(fetch && j <= 1024);
      chk("wr_gnt", wr_gnt, exp_gnt);
      if (wr_gnt) grants++;
      @(posedge clk); #1;
      exp_re   = fetch && j >= 1 && j <= 1024;
      exp_lbwe = fetch && j >= 2 && j <= 1025;
      chk("fetch_busy", fetch_busy, fetch && j <= 1023);
      chk("mem_re", mem_re, exp_re);
      chk("mem_we", mem_we, exp_gnt);
      if (exp_re) chk("mem_addr_rd", mem_addr, base + 20'(j - 1));
      if (exp_gnt) begin
        chk("mem_addr_wr", mem_addr, wa_g);
        chk("mem_wdata", mem_wdata, {4'h5, wa_g});
        wa_g++;
      end
      chk("lb_we", lb_we, exp_lbwe);
      if (exp_lbwe) begin
        chk("lb_addr", lb_addr, {bank, 10'(j - 2)});
        chk("lb_wdata", lb_wdata, {4'hA, base + 20'(j - 2)});
      end
      chk("overrun", overrun, exp_ovr);
    end
    chk("grant_count", grants, req ? (fetch ? 319 : 1344) : 0);
  endtask

  initial begin
    int re_cnt;
    int busy_cnt;
    reset   = 1'b0;
    wr_req  = 1'b1;
    wr_addr = wa_g;
    wr_data = {4'h5, wa_g};
    h_count = 11'd5;
    v_count = 10'd0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_lb_we", lb_we, 0);
      chk("rst_busy", fetch_busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_lb_addr", lb_addr, 0);
    end

    reset = 1'b1;
    #1;
    chk("post_rst_gnt", wr_gnt, 1);
    @(posedge clk); #1;
    chk("first_we", mem_we, 1);
    chk("first_waddr", mem_addr, wa_g);
    chk("first_wdata", mem_wdata, {4'h5, wa_g});
    wa_g++;
    wr_req = 1'b0;
    @(posedge clk); #1;
    chk("we_drop", mem_we, 0);

    run_line(37, 1'b1, 1'b0);
    run_line(40, 1'b1, 1'b1);
    run_line(10, 1'b0, 1'b1);
    run_line(804, 1'b1, 1'b1);
    run_line(805, 1'b0, 1'b1);

    // Second trigger mid-burst must be ignored apart from raising overrun.
    wr_req   = 1'b0;
    v_count  = 10'd39;
    re_cnt   = 0;
    busy_cnt = 0;
    for (int j = 0; j < 1200; j++) begin
      h_count = (j == 100) ? 11'd0 : 11'(j);
      @(posedge clk); #1;
      if (mem_re) re_cnt++;
      if (fetch_busy) busy_cnt++;
      if (j == 100) chk("ovr_set", overrun, 1);
      if (j == 1024) chk("ovr_last_addr", mem_addr, 20'd2048 + 20'd1023);
    end
    chk("ovr_re_count", re_cnt, 1024);
    chk("ovr_busy_count", busy_cnt, 1024);
    chk("ovr_sticky", overrun, 1);

    // Reset in the middle of a burst, while a read is outstanding.
    v_count = 10'd38;
    for (int j = 0; j < 50; j++) begin
      h_count = 11'(j);
      @(posedge clk); #1;
    end
    chk("pre_rst_lb_we", lb_we, 1);
    h_count = 11'd60;
    reset   = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_mem_re", mem_re, 0);
    chk("mid_rst_lb_we", lb_we, 0);
    chk("mid_rst_mem_we", mem_we, 0);
    chk("mid_rst_busy", fetch_busy, 0);
    chk("mid_rst_overrun", overrun, 0);
    reset   = 1'b1;
    exp_ovr = 1'b0;
    run_line(38, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
